// File: rtl/arb_requester_if.sv
// Request/grant pair between a requester and the arbiter that answers it.
// The requester drives request; the arbiter drives grant.
interface arb_requester_if;
  logic [1:0] request;
  logic [1:0] grant;

  modport master (output request, input grant);
  modport slave  (input request, output grant);
endinterface

// File: rtl/arb_requester.sv
// Two-channel initiator for the request/grant arbitration protocol: each channel
// requests, owns the bus for a programmed number of granted beats, then releases.
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       start,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  arb_requester_if.master  arb,
  output logic [1:0]       busy,
  output logic [1:0]       done,
  output logic [1:0]       timeout,
  output logic             err_spurious
);

  typedef enum logic [1:0] {IDLE, REQ, OWN} state_t;

  localparam logic [LEN_W-1:0] BEAT_ONE = LEN_W'(1);
  localparam logic [7:0]       TO_CNT   = 8'(TIMEOUT);

  logic [LEN_W-1:0] len_arr [2];
  assign len_arr[0] = len0;
  assign len_arr[1] = len1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      state_t           state_reg, state_next;
      logic [LEN_W-1:0] beat_reg, beat_next;
      logic [7:0]       wait_reg, wait_next, wait_inc;
      logic             done_next, timeout_next;
      logic             req_reg, busy_reg, done_reg, timeout_reg;

      // Saturating increment so a wait count can never wrap back to zero.
      assign wait_inc = (wait_reg == 8'hff) ? wait_reg : wait_reg + 8'd1;

      always_comb begin
        state_next   = state_reg;
        beat_next    = beat_reg;
        wait_next    = wait_reg;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
          IDLE: begin
            if (start[gi]) begin
              beat_next  = (len_arr[gi] == '0) ? BEAT_ONE : len_arr[gi];
              wait_next  = 8'd0;
              state_next = REQ;
            end
          end
          REQ: begin
            // The granting cycle is already the first beat of the burst.
            if (arb.grant[gi]) begin
              if (beat_reg == BEAT_ONE) begin
                done_next  = 1'b1;
                state_next = IDLE;
              end else begin
                beat_next  = beat_reg - BEAT_ONE;
                state_next = OWN;
              end
            end else begin
              wait_next = wait_inc;
              if (wait_inc >= TO_CNT) begin
                timeout_next = 1'b1;
                state_next   = IDLE;
              end
            end
          end
          OWN: begin
            // Preemption simply freezes the beat count; ownership is kept.
            if (arb.grant[gi]) begin
              if (beat_reg == BEAT_ONE) begin
                done_next  = 1'b1;
                state_next = IDLE;
              end else begin
                beat_next = beat_reg - BEAT_ONE;
              end
            end
          end
          default: state_next = IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg   <= IDLE;
          beat_reg    <= '0;
          wait_reg    <= 8'd0;
          req_reg     <= 1'b0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
          timeout_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          beat_reg    <= beat_next;
          wait_reg    <= wait_next;
          req_reg     <= (state_next != IDLE);
          busy_reg    <= (state_next != IDLE);
          done_reg    <= done_next;
          timeout_reg <= timeout_next;
        end
      end

      assign arb.request[gi] = req_reg;
      assign busy[gi]        = busy_reg;
      assign done[gi]        = done_reg;
      assign timeout[gi]     = timeout_reg;
    end
  endgenerate

  // Grant to a channel not currently requesting, or to both at once, is illegal.
  logic err_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (((arb.grant & ~arb.request) != 2'b00) || (arb.grant == 2'b11)) begin
      err_reg <= 1'b1;
    end
  end
  assign err_spurious = err_reg;

endmodule

// File: tb/tb_arb_requester.sv
// Randomized and directed bench for arb_requester against a beat-counting
// reference model of the request/grant protocol.
module tb_arb_requester;
  localparam int LEN_W = 4;
  localparam int TMO   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic [1:0] busy, done, timeout;
  logic       err_spurious;

  arb_requester_if bus();

  arb_requester #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len0         (len0),
    .len1         (len1),
    .arb          (bus.master),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  // Reference model: beats remaining (0 = idle), cycles waited, ownership seen.
  int         remain [2];
  int         waited [2];
  bit         owned  [2];
  logic [1:0] m_req, m_done, m_to;
  logic       m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      remain[c] = 0;
      waited[c] = 0;
      owned[c]  = 1'b0;
    end
    m_req  = 2'b00;
    m_done = 2'b00;
    m_to   = 2'b00;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] g;
    int l;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = bus.grant;
    if (((g & ~m_req) != 2'b00) || (g == 2'b11)) m_err = 1'b1;
    for (int c = 0; c < 2; c++) begin
      l = (c == 0) ? int'(len0) : int'(len1);
      m_done[c] = 1'b0;
      m_to[c]   = 1'b0;
      if (remain[c] == 0) begin
        if (start[c]) begin
          remain[c] = (l == 0) ? 1 : l;
          waited[c] = 0;
          owned[c]  = 1'b0;
        end
      end else if (g[c]) begin
        remain[c] = remain[c] - 1;
        owned[c]  = 1'b1;
        if (remain[c] == 0) begin
          m_done[c] = 1'b1;
          $display("t=%0t ch%0d burst done", $time, c);
        end
      end else if (!owned[c]) begin
        waited[c] = waited[c] + 1;
        if (waited[c] >= TMO) begin
          m_to[c]   = 1'b1;
          remain[c] = 0;
          $display("t=%0t ch%0d request timed out", $time, c);
        end
      end
      m_req[c] = (remain[c] != 0);
    end
  endtask

  task automatic check_outputs();
    chk("request", int'(bus.request), int'(m_req));
    chk("busy", int'(busy), int'(m_req));
    chk("done", int'(done), int'(m_done));
    chk("timeout", int'(timeout), int'(m_to));
    chk("err_spurious", int'(err_spurious), int'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic cyc(input logic [1:0] s, input logic [3:0] l0, input logic [3:0] l1,
                     input logic [1:0] g);
    start     = s;
    len0      = l0;
    len1      = l1;
    bus.grant = g;
    step();
    start = 2'b00;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    chk("async_request", int'(bus.request), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_timeout", int'(timeout), 0);
    chk("async_err", int'(err_spurious), 0);
    model_reset();
    start     = 2'b00;
    bus.grant = 2'b00;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic [1:0] g;
    logic [1:0] pat [6];
    bus.grant = 2'b00;
    model_reset();
    #1;
    check_outputs();
    step();
    step();
    rst_n = 1'b1;

    // Single burst of 3
    cyc(2'b01, 4'd3, 4'd0, 2'b00);
    k = 0;
    do begin cyc(2'b00, 4'd0, 4'd0, 2'b01); k++; end while (!done[0] && k < 20);
    chk("t1_granted_beats", k, 3);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Timeout on channel 1
    cyc(2'b10, 4'd0, 4'd0, 2'b00);
    k = 0;
    do begin cyc(2'b00, 4'd0, 4'd0, 2'b00); k++; end while (!timeout[1] && k < 20);
    chk("t2_wait_cycles", k, TMO);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Preemption with grant 1,1,0,0,1,1 and len 4
    pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b00;
    pat[3] = 2'b00; pat[4] = 2'b01; pat[5] = 2'b01;
    cyc(2'b01, 4'd4, 4'd0, 2'b00);
    k = 0;
    do begin cyc(2'b00, 4'd0, 4'd0, pat[k]); k++; end while (!done[0] && k < 6);
    chk("t3_preempt_steps", k, 6);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Both channels, served 01 then 10
    cyc(2'b11, 4'd2, 4'd2, 2'b00);
    cyc(2'b00, 4'd0, 4'd0, 2'b01);
    cyc(2'b00, 4'd0, 4'd0, 2'b01);
    cyc(2'b00, 4'd0, 4'd0, 2'b10);
    cyc(2'b00, 4'd0, 4'd0, 2'b10);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Protocol violations
    cyc(2'b00, 4'd0, 4'd0, 2'b01);
    repeat (3) cyc(2'b00, 4'd0, 4'd0, 2'b00);
    rst_pulse();
    cyc(2'b11, 4'd5, 4'd5, 2'b00);
    cyc(2'b00, 4'd0, 4'd0, 2'b11);
    repeat (3) cyc(2'b00, 4'd0, 4'd0, 2'b00);
    rst_pulse();

    // Reset mid-burst, then verify no stray done
    cyc(2'b01, 4'd8, 4'd0, 2'b00);
    repeat (3) cyc(2'b00, 4'd0, 4'd0, 2'b01);
    rst_pulse();
    repeat (10) cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // len 0 behaves as 1, len 15 is the maximum
    cyc(2'b01, 4'd0, 4'd0, 2'b00);
    k = 0;
    do begin cyc(2'b00, 4'd0, 4'd0, 2'b01); k++; end while (!done[0] && k < 20);
    chk("len0_beats", k, 1);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);
    cyc(2'b01, 4'd15, 4'd0, 2'b00);
    k = 0;
    do begin cyc(2'b00, 4'd0, 4'd0, 2'b01); k++; end while (!done[0] && k < 30);
    chk("len15_beats", k, 15);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Randomized traffic with a mostly well-behaved arbiter
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_pulse();
      end else begin
        g = m_req & 2'($urandom);
        if ($urandom_range(0, 99) < 2) g = 2'($urandom);
        cyc(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
            4'($urandom), 4'($urandom), g);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
